redun_mont_sq_seq: RTL and testbench

Iteration sequencer that drives `multi_mode_multiplier` to perform repeated redundant-form Montgomery squaring: x <- x^2 * R^-1 mod N, T times. It sits directly upstream of the multiplier. It owns the working value, issues the three multiplier phases per iteration (square, low multiply by N', high multiply by N), and routes the returned words back into the next phase. It presents the final redundant result to the VDF top level with a done pulse.

---
 rtl/redun_mont_sq_seq.sv | 172 +++++++++++++++++
 tb/tb_redun_mont_sq_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/redun_mont_sq_seq.sv
// rtl/redun_mont_sq_seq.sv - iteration sequencer for repeated redundant-form Montgomery squaring
//
// Purpose: owns the working value x and runs T iterations of x <- x^2 * R^-1 mod N.
// Each iteration issues three multiplier phases: SQ (x*x), LO (sq_lo*N'), and
// HI (m*N + sq_hi). Words are passed through as stored, so no normalisation is done.
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_start, i_iter, i_x   start pulse with iteration count and initial value
//   i_mod, i_mod_inv       modulus N and N' = -N^-1 mod R (static while busy)
//   o_mul_ctl              multiplier mode (0 low, 1 high, 2 square)
//   o_mul_a/b/add          multiplier operands and add term
//   i_mul_dat              multiplier result, valid MUL_LAT cycles after issue
//   o_busy, o_done, o_x    status and result register
module redun_mont_sq_seq #(
  parameter int NUM_ELEMENTS = 33,
  parameter int DSP_BIT_LEN  = 17,
  parameter int WORD_LEN     = 16,
  parameter int MUL_LAT      = 3,
  parameter int ITER_BITS    = 32
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst_n,
  input  logic                                    i_start,
  input  logic [ITER_BITS-1:0]                    i_iter,
  input  logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]     i_x,
  input  logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]     i_mod,
  input  logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]     i_mod_inv,
  output logic [1:0]                              o_mul_ctl,
  output logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]     o_mul_a,
  output logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]     o_mul_b,
  output logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]     o_mul_add,
  input  logic [2*DSP_BIT_LEN*NUM_ELEMENTS-1:0]   i_mul_dat,
  output logic                                    o_busy,
  output logic                                    o_done,
  output logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]     o_x
);

  localparam int W    = DSP_BIT_LEN * NUM_ELEMENTS;
  localparam int PC_W = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(MUL_LAT);

  // Elaboration-time guards: the multiplier needs at least one cycle and each
  // stored word must carry at least one redundant bit above the radix.
  if (MUL_LAT < 1) begin : g_bad_lat
    $error("MUL_LAT must be at least 1");
  end
  if (DSP_BIT_LEN <= WORD_LEN) begin : g_bad_word
    $error("DSP_BIT_LEN must exceed WORD_LEN");
  end

  typedef enum logic [2:0] {S_IDLE, S_SQ, S_LO, S_HI, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [ITER_BITS-1:0]  iter_q, iter_d, iter_dec;
  logic [W-1:0]          x_q, x_d;
  logic [W-1:0]          sq_lo_q, sq_lo_d;
  logic [W-1:0]          sq_hi_q, sq_hi_d;
  logic [W-1:0]          m_q, m_d;
  logic [W-1:0]          o_x_q, o_x_d;
  // Cleared by reset, set one edge later: a start coincident with reset
  // release is therefore never accepted.
  logic                  armed_q;
  logic                  phase_end;
  logic [W-1:0]          dat_lo, dat_hi;

  assign dat_lo    = i_mul_dat[W-1:0];
  assign dat_hi    = i_mul_dat[2*W-1:W];
  assign phase_end = (pc_q == PC_LAST);
  assign iter_dec  = iter_q - ITER_BITS'(1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    iter_d    = iter_q;
    x_d       = x_q;
    sq_lo_d   = sq_lo_q;
    sq_hi_d   = sq_hi_q;
    m_d       = m_q;
    o_x_d     = o_x_q;
    o_mul_ctl = 2'd0;
    o_mul_a   = '0;
    o_mul_b   = '0;
    o_mul_add = '0;

    // Phase counter free-runs 0..MUL_LAT inside the three multiplier phases.
    if (state_q == S_SQ || state_q == S_LO || state_q == S_HI) begin
      pc_d = phase_end ? '0 : pc_q + PC_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (i_start && armed_q) begin
          x_d     = i_x;
          iter_d  = i_iter;
          state_d = (i_iter == '0) ? S_DONE : S_SQ;
        end
      end
      S_SQ: begin
        o_mul_ctl = 2'd2;
        o_mul_a   = x_q;
        o_mul_b   = x_q;
        if (phase_end) begin
          sq_lo_d = dat_lo;
          sq_hi_d = dat_hi;
          state_d = S_LO;
        end
      end
      S_LO: begin
        o_mul_ctl = 2'd0;
        o_mul_a   = sq_lo_q;
        o_mul_b   = i_mod_inv;
        if (phase_end) begin
          m_d     = dat_lo;
          state_d = S_HI;
        end
      end
      S_HI: begin
        o_mul_ctl = 2'd1;
        o_mul_a   = m_q;
        o_mul_b   = i_mod;
        o_mul_add = sq_hi_q;
        if (phase_end) begin
          x_d     = dat_hi;
          iter_d  = iter_dec;
          state_d = (iter_dec == '0) ? S_DONE : S_SQ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Load the result register on entry to DONE so o_x is valid with o_done.
    if (state_d == S_DONE && state_q != S_DONE) begin
      o_x_d = x_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      iter_q  <= '0;
      x_q     <= '0;
      sq_lo_q <= '0;
      sq_hi_q <= '0;
      m_q     <= '0;
      o_x_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      iter_q  <= iter_d;
      x_q     <= x_d;
      sq_lo_q <= sq_lo_d;
      sq_hi_q <= sq_hi_d;
      m_q     <= m_d;
      o_x_q   <= o_x_d;
      armed_q <= 1'b1;
    end
  end

  assign o_busy = (state_q != S_IDLE);
  assign o_done = (state_q == S_DONE);
  assign o_x    = o_x_q;

endmodule

// File: tb/tb_redun_mont_sq_seq.sv
// tb/tb_redun_mont_sq_seq.sv - self-checking bench for redun_mont_sq_seq with a latency-accurate multiplier model
module tb_redun_mont_sq_seq;

  localparam int NE  = 4;
  localparam int DSP = 17;
  localparam int WL  = 16;
  localparam int LAT = 3;
  localparam int IB  = 32;
  localparam int W   = DSP * NE;
  localparam int W2  = 2 * W;
  localparam int PH  = LAT + 1;

  typedef logic [255:0] big_t;

  typedef struct {
    int            t;
    int            exp_cyc;
    logic [W-1:0]  x;
    big_t          rhs;
    big_t          rfac;
  } sb_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [IB-1:0]   iter = '0;
  logic [W-1:0]    x_in = '0;
  logic [W-1:0]    mod_w, modinv_w;
  logic [1:0]      mctl;
  logic [W-1:0]    ma, mb, madd;
  logic [W2-1:0]   mdat;
  logic            busy, done;
  logic [W-1:0]    ox;

  logic [W2-1:0]   pipe [LAT];
  sb_t             sb[$];
  big_t            N, R, NINV;
  logic [W-1:0]    last_ox;
  int              total = 0;
  int              bad = 0;

  always #5 clk = ~clk;

  redun_mont_sq_seq #(
    .NUM_ELEMENTS(NE), .DSP_BIT_LEN(DSP), .WORD_LEN(WL), .MUL_LAT(LAT), .ITER_BITS(IB)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_iter(iter), .i_x(x_in),
    .i_mod(mod_w), .i_mod_inv(modinv_w), .o_mul_ctl(mctl), .o_mul_a(ma), .o_mul_b(mb),
    .o_mul_add(madd), .i_mul_dat(mdat), .o_busy(busy), .o_done(done), .o_x(ox)
  );

  function automatic big_t val(input logic [W2-1:0] v, input int nw);
    big_t acc = '0;
    for (int k = 0; k < nw; k++) acc = acc + (big_t'(v[k*DSP +: DSP]) << (WL * k));
    return acc;
  endfunction

  function automatic logic [W2-1:0] pack(input big_t v, input int nw);
    logic [W2-1:0] o = '0;
    for (int k = 0; k < nw; k++) o[k*DSP +: DSP] = {1'b0, v[k*WL +: WL]};
    return o;
  endfunction

  // Multiplier behaviour: square/low return the full product plus add;
  // high returns floor(P/R) + add + (P mod R != 0) in the upper half, which is
  // exactly (t + m*N)/R once m has cancelled the low half of t.
  function automatic logic [W2-1:0] mul_model(input logic [1:0] c, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic [W-1:0] ad);
    big_t p, lo, hi;
    p = val(W2'(a), NE) * val(W2'(b), NE);
    if (c == 2'd1) begin
      lo = p % R;
      hi = p / R + val(W2'(ad), NE) + ((lo != '0) ? big_t'(1) : big_t'(0));
      return pack((hi << (WL * NE)) | lo, 2 * NE);
    end
    return pack(p + val(W2'(ad), NE), 2 * NE);
  endfunction

  always @(posedge clk) begin
    pipe[0] <= mul_model(mctl, ma, mb, madd);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mdat = pipe[LAT-1];

  task automatic check(input string tag, input big_t obs, input big_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input int t, input logic [W-1:0] x);
    sb_t e;
    big_t r;
    int n;
    @(negedge clk);
    start = 1'b1;
    iter  = IB'(t);
    x_in  = x;
    e.t = t;
    e.exp_cyc = 1 + 3 * t * PH;
    e.x = x;
    r = val(W2'(x), NE) % N;
    for (int i = 0; i < t; i++) r = (r * r) % N;
    e.rhs = r;
    e.rfac = 1;
    n = (1 << t) - 1;
    for (int i = 0; i < n; i++) e.rfac = (e.rfac * (R % N)) % N;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int p1, input int p2);
    int t, ec, ph, ectl;
    bit got, ok;
    sb_t e;
    big_t lhs;
    got = 0;
    t  = sb[0].t;
    ec = sb[0].exp_cyc;
    for (int c = 1; c <= ec + 20 && !got; c++) begin
      @(negedge clk);
      start = (c == p1) || (c == p2);
      if (c <= ec) begin
        if (c == ec) begin
          ectl = 0;
          ok = (ma === '0) && (mb === '0) && (madd === '0);
        end else begin
          ph = ((c - 1) / PH) % 3;
          case (ph)
            0: begin ectl = 2; ok = (ma === mb) && (madd === '0); end
            1: begin ectl = 0; ok = (mb === modinv_w) && (madd === '0); end
            default: begin ectl = 1; ok = (mb === mod_w); end
          endcase
        end
        check($sformatf("phase_c%0d", c), {busy, mctl, ok}, {1'b1, 2'(ectl), 1'b1});
      end
      if (done === 1'b1) begin
        got = 1;
        e = sb.pop_front();
        last_ox = ox;
        check("done_cycle", big_t'(c), big_t'(e.exp_cyc));
        if (e.t == 0) begin
          check("x_pass", ox, e.x);
        end else begin
          lhs = ((val(W2'(ox), NE) % N) * e.rfac) % N;
          check($sformatf("mont_res_t%0d", e.t), lhs, e.rhs);
        end
      end
    end
    start = 1'b0;
    if (!got) begin
      check("done_timeout", 0, 1);
      void'(sb.pop_front());
    end
  endtask

  task automatic idle_check(input int n, input logic [W-1:0] hold);
    int errs = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || ox !== hold) errs++;
    end
    check("idle_hold", errs, 0);
  endtask

  function automatic logic [W-1:0] rand_x();
    big_t v = {$urandom, $urandom};
    return W'(pack(v % N, NE));
  endfunction

  initial begin
    logic [W-1:0] xa;
    int dn;
    R = big_t'(1) << (WL * NE);
    N = 256'h2f3c5a1b9d7e4c35;
    NINV = N;
    for (int i = 0; i < 7; i++) NINV = (NINV * (big_t'(2) - N * NINV)) & (R - 1);
    NINV = (R - NINV) & (R - 1);
    mod_w    = W'(pack(N, NE));
    modinv_w = W'(pack(NINV, NE));
    check("ninv_valid", (N * NINV + 1) % R, 0);

    // Reset state, then a start coincident with reset release is ignored.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stat", {busy, done, mctl}, 0);
    check("rst_ops", {ma, mb, madd}, 0);
    check("rst_ox", ox, 0);
    rst_n = 1'b1;
    start = 1'b1;
    iter  = 5;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("start_at_release", busy, 0);

    // T=0: direct pass-through, done in cycle 1.
    xa = {17'd4, 17'd3, 17'd2, 17'd1};
    start_run(0, xa);
    wait_done(0, 0);
    idle_check(3, xa);

    // T=1 on the Montgomery one.
    start_run(1, W'(pack(R % N, NE)));
    wait_done(0, 0);
    check("mont_one", val(W2'(last_ox), NE) % N, R % N);

    // T=3 random with ignored start pulses.
    start_run(3, rand_x());
    wait_done(5, 20);
    idle_check(20, last_ox);

    // Reset mid-run aborts; then a T=1 restart.
    start_run(2, rand_x());
    dn = 0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (done !== 1'b0) dn++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_stat", {busy, done, mctl}, 0);
    check("abort_ops", {ma, mb, madd}, 0);
    check("abort_ox", ox, 0);
    sb.delete();
    repeat (2) begin
      @(negedge clk);
      if (done !== 1'b0) dn++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done !== 1'b0) dn++;
    end
    check("abort_no_done", dn, 0);
    start_run(1, rand_x());
    wait_done(0, 0);

    // Back-to-back runs.
    start_run(2, rand_x());
    wait_done(0, 0);
    start_run(1, rand_x());
    wait_done(0, 0);
    idle_check(5, last_ox);

    // Redundant carry bits pass through untouched.
    xa = {17'h1ffff, 17'h10001, 17'h10000, 17'h0abcd};
    start_run(0, xa);
    wait_done(0, 0);
    idle_check(2, xa);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
